pool_stream_collector: RTL and testbench
========================================

Name: pool_stream_collector

Overview:
- Downstream stage of the conv/ReLU/pool pipeline. Consumes the pooled result stream (dout/valid_out), which cannot be stalled.
- Tags each pixel with frame position (start-of-frame, end-of-line, end-of-frame) and buffers it in a small FIFO.
- Presents the buffered pixels to a host/DMA consumer over a valid/ready interface.
- Tracks frame completion and flags data loss when the consumer applies too much backpressure.

Parameters:
- DATA_W, 8, pixel width (signed).
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- ADDR_W, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- frame_start  in  1  pulse; arms collection of one frame (honoured only in IDLE).
- out_width  in  8  pooled map width; sampled on an accepted frame_start.
- out_height  in  8  pooled map height; sampled on an accepted frame_start.
- in_valid  in  1  pooled pixel valid; no backpressure to source.
- in_data  in  DATA_W  pooled pixel, signed.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accepts head.
- m_data  out  DATA_W  head pixel.
- m_sof  out  1  head is pixel (0,0).
- m_eol  out  1  head is last column of its row.
- m_eof  out  1  head is last pixel of frame.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.
- overflow  out  1  sticky; at least one pixel was dropped this frame.
- fill  out  ADDR_W+1  current FIFO occupancy.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE; FIFO pointers and fill go to 0; row/col counters go to 0.
  - All outputs go to 0, including m_valid, m_data, tags, busy, frame_done and overflow.
  - Reset mid-frame discards FIFO contents with no frame_done.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - frame_start with out_width != 0 and out_height != 0: latch dims, clear overflow, clear counters, next state COLLECT.
  - frame_start with either dim == 0: frame_done pulses the next cycle; stay IDLE.
  - in_valid in IDLE is ignored (not pushed).
- COLLECT:
  - Each in_valid is one pixel position; col increments, wraps to 0 at width-1, and row then increments.
  - Tags are computed from the counters at push time:
    - sof = (row==0 && col==0)
    - eol = (col==W-1)
    - eof = (row==H-1 && col==W-1)
  - When the eof pixel is consumed (pushed or dropped), next state is DRAIN.
- DRAIN:
  - Further in_valid is ignored.
  - When the FIFO is empty: frame_done pulses for 1 cycle and the next state is IDLE.
  - The check uses registered fill == 0.
- frame_start while busy is ignored.
- FIFO:
  - 11-bit entries: {eof, eol, sof, data}.
  - Push = in_valid in COLLECT and (not full, or pop in the same cycle).
  - Pop = m_valid && m_ready.
  - Simultaneous push and pop at full: both succeed; fill is unchanged.
  - Simultaneous push and pop at empty: not permitted as pass-through. The pushed pixel appears on m_valid the next cycle.
  - Latency from in_valid to m_valid is 1 cycle when empty.
  - m_data and tags are driven from the head entry; they stay stable while m_valid && !m_ready.
- Overflow: in_valid in COLLECT while full with no pop drops the pixel and sets overflow. Counters still advance, so subsequent tags stay positionally correct.
- Widths: counters are 8 bits; no arithmetic on data (pass-through).

Decomposition:
- Shared package (pipeline_pkg): DATA_W, the tag bit positions, and the FSM state encoding localparams.
- One natural sub-module: sync_fifo (parameterised DATA width/DEPTH, registered pointers, full/empty/fill, no fall-through).
- Counters and FSM stay in pool_stream_collector.

Test Plan:
- Basic frame:
  - Stimulus: out_width=3, out_height=3; frame_start; 9 back-to-back in_valid with data 1..9; m_ready=1.
  - Required: 9 beats 1..9; m_sof on 1; m_eol on 3, 6, 9; m_eof on 9; frame_done 1 cycle after beat 9 pops; busy low afterwards.
- Backpressure overflow:
  - Stimulus: 4x5 frame, m_ready=0 throughout; 20 pixels.
  - Required: fill saturates at 16; overflow=1; after releasing m_ready, exactly 16 beats (pixels 1..16); m_eof never seen; frame_done still pulses.
- Full with simultaneous pop:
  - Stimulus: fill FIFO to 16, then in_valid and m_ready high together for 4 cycles.
  - Required: fill stays 16; overflow stays 0; no data lost.
- Zero dims:
  - Stimulus: out_width=0, out_height=4; frame_start.
  - Required: frame_done pulse next cycle; busy stays 0; later in_valid is ignored (fill=0).
- Reset mid-frame:
  - Stimulus: rst asserted after 5 of 9 pixels.
  - Required: next cycle m_valid=0, fill=0, busy=0, overflow=0; no frame_done.
- Busy re-arm:
  - Stimulus: frame_start during COLLECT.
  - Required: ignored; counters and dims unchanged; the frame completes normally.

Source files
------------

// File: rtl/pool_stream_collector_pkg.sv
// pool_stream_collector_pkg: shared widths, FIFO entry tag offsets and FSM states
package pool_stream_collector_pkg;
  localparam int DATA_W  = 8;
  localparam int TAG_SOF = 0;
  localparam int TAG_EOL = 1;
  localparam int TAG_EOF = 2;
  localparam int TAG_N   = 3;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_e;
endpackage

// File: rtl/pool_stream_collector_fifo.sv
// pool_stream_collector_fifo: registered-pointer sync FIFO without fall-through
module pool_stream_collector_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   fill
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign rdata = mem_q[rd_q];
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign fill  = cnt_q;
endmodule

// File: rtl/pool_stream_collector.sv
// pool_stream_collector: tags pooled pixels with frame position and buffers them
// for a valid/ready consumer, tracking frame completion and dropped pixels.
module pool_stream_collector #(
  parameter int DATA_W     = pool_stream_collector_pkg::DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [7:0]        out_width,
  input  logic [7:0]        out_height,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W:0]   fill
);
  import pool_stream_collector_pkg::*;
  localparam int ENTRY_W = DATA_W + TAG_N;
  state_e             state_q;
  logic [7:0]         w_q, h_q, row_q, col_q;
  logic               overflow_q, frame_done_q;
  logic               full, empty, push, pop, collect, at_sof, at_eol, at_eof;
  logic [ENTRY_W-1:0] wdata, rdata;
  always_comb begin
    collect = state_q == S_COLLECT && in_valid;
    at_sof  = row_q == 8'd0 && col_q == 8'd0;
    at_eol  = col_q == w_q - 8'd1;
    at_eof  = at_eol && row_q == h_q - 8'd1;
    pop     = !empty && m_ready;
    push    = collect && (!full || pop);
    wdata   = {at_eof, at_eol, at_sof, in_data};
  end
  pool_stream_collector_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );
  // Head fields are gated so nothing stale from the unreset FIFO memory leaks out.
  assign m_valid    = !empty;
  assign m_data     = empty ? '0 : rdata[DATA_W-1:0];
  assign m_sof      = !empty && rdata[DATA_W+TAG_SOF];
  assign m_eol      = !empty && rdata[DATA_W+TAG_EOL];
  assign m_eof      = !empty && rdata[DATA_W+TAG_EOF];
  assign busy       = state_q != S_IDLE;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      w_q          <= '0;
      h_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (frame_start) begin
          if (out_width != 8'd0 && out_height != 8'd0) begin
            w_q        <= out_width;
            h_q        <= out_height;
            row_q      <= '0;
            col_q      <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_COLLECT;
          end else frame_done_q <= 1'b1;
        end
        // Counters advance even on a dropped pixel so later tags stay positional.
        S_COLLECT: if (in_valid) begin
          col_q <= at_eol ? 8'd0 : col_q + 8'd1;
          row_q <= row_q + 8'(at_eol);
          if (!push) overflow_q <= 1'b1;
          if (at_eof) state_q <= S_DRAIN;
        end
        S_DRAIN: if (fill == '0) begin
          frame_done_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_stream_collector.sv
// tb_pool_stream_collector: randomized and directed frames against a queue-based reference model
module tb_pool_stream_collector;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic [7:0] out_width = 8'd0, out_height = 8'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       m_ready = 1'b0;
  logic       m_valid, m_sof, m_eol, m_eof, busy, frame_done, overflow;
  logic [7:0] m_data;
  logic [4:0] fill;
  int checks = 0, errors = 0;
  logic [10:0] q[$];
  bit m_col = 0, m_drn = 0, m_ovf = 0, m_fd = 0;
  int m_w = 0, m_h = 0, m_idx = 0, beats = 0, eofs = 0;

  always #5 clk = ~clk;

  pool_stream_collector dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .out_width(out_width),
    .out_height(out_height), .in_valid(in_valid), .in_data(in_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
    .m_eol(m_eol), .m_eof(m_eof), .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .fill(fill)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: pixel index -> (row, col) by division, FIFO as a 16-deep queue.
  task automatic model_step();
    bit was_busy, pop, do_push;
    int r, c;
    logic [10:0] e;
    do_push = 0;
    e = '0;
    if (rst) begin
      q.delete();
      m_col = 0; m_drn = 0; m_ovf = 0; m_fd = 0;
      return;
    end
    was_busy = m_col || m_drn;
    pop = q.size() > 0 && m_ready;
    m_fd = 0;
    if (m_drn && q.size() == 0) begin
      m_fd = 1;
      m_drn = 0;
    end else if (m_col && in_valid) begin
      r = m_idx / m_w;
      c = m_idx % m_w;
      e = {r == m_h - 1 && c == m_w - 1, c == m_w - 1, m_idx == 0, in_data};
      if (q.size() < 16 || pop) do_push = 1;
      else m_ovf = 1;
      m_idx++;
      if (m_idx == m_w * m_h) begin
        m_col = 0;
        m_drn = 1;
      end
    end
    if (frame_start && !was_busy) begin
      if (out_width != 0 && out_height != 0) begin
        m_w = out_width; m_h = out_height; m_idx = 0; m_ovf = 0; m_col = 1;
      end else m_fd = 1;
    end
    if (pop) begin
      beats++;
      if (q[0][10]) eofs++;
      void'(q.pop_front());
    end
    if (do_push) q.push_back(e);
  endtask

  task automatic check_all();
    check("m_valid", m_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("m_data", m_data, q[0][7:0]);
      check("m_sof", m_sof, q[0][8]);
      check("m_eol", m_eol, q[0][9]);
      check("m_eof", m_eof, q[0][10]);
    end
    check("fill", fill, q.size());
    check("busy", busy, m_col || m_drn);
    check("overflow", overflow, m_ovf);
    check("frame_done", frame_done, m_fd);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic start(input int w, input int h);
    out_width = 8'(w); out_height = 8'(h);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    beats = 0; eofs = 0;
  endtask

  task automatic px(input logic [7:0] d, input logic rdy);
    in_valid = 1'b1; in_data = d; m_ready = rdy;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish();
    int n;
    n = 0;
    in_valid = 1'b0; m_ready = 1'b1;
    while ((m_col || m_drn) && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check("drain_timeout", 1, 0);
    tick();
    tick();
  endtask

  initial begin
    int w, h, rp;
    tick();
    tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_tags", {m_sof, m_eol, m_eof}, 0);
    check("rst_busy", busy, 0);
    check("rst_fill", fill, 0);
    rst = 1'b0;
    tick();
    // basic 3x3 frame
    start(3, 3);
    for (int i = 1; i <= 9; i++) px(8'(i), 1'b1);
    finish();
    check("basic_beats", beats, 9);
    check("basic_eof", eofs, 1);
    // backpressure overflow
    start(4, 5);
    for (int i = 1; i <= 20; i++) px(8'(i), 1'b0);
    check("bp_fill", fill, 16);
    check("bp_overflow", overflow, 1);
    finish();
    check("bp_beats", beats, 16);
    check("bp_eof", eofs, 0);
    // full with simultaneous pop
    start(5, 5);
    for (int i = 1; i <= 16; i++) px(8'(i), 1'b0);
    for (int i = 17; i <= 20; i++) px(8'(i), 1'b1);
    check("fullpop_fill", fill, 16);
    check("fullpop_overflow", overflow, 0);
    for (int i = 21; i <= 25; i++) px(8'(i), 1'b1);
    finish();
    check("fullpop_beats", beats, 25);
    // zero dims
    start(0, 4);
    check("zero_busy", busy, 0);
    for (int i = 0; i < 3; i++) px(8'($urandom), 1'b1);
    check("zero_fill", fill, 0);
    // reset mid-frame
    start(3, 3);
    for (int i = 0; i < 5; i++) px(8'($urandom), 1'($urandom));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_m_valid", m_valid, 0);
    check("mrst_fill", fill, 0);
    check("mrst_busy", busy, 0);
    check("mrst_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) tick();
    // frame_start while busy is ignored
    start(3, 3);
    for (int i = 0; i < 4; i++) px(8'($urandom), 1'b1);
    out_width = 8'd7; out_height = 8'd2; frame_start = 1'b1;
    px(8'($urandom), 1'b1);
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) px(8'($urandom), 1'b1);
    finish();
    check("rearm_beats", beats, 9);
    check("rearm_eof", eofs, 1);
    // random frames
    for (int f = 0; f < 20; f++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 6);
      rp = $urandom_range(10, 100);
      start(w, h);
      for (int i = 0; i < w * h; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          m_ready = 1'($urandom_range(0, 99) < rp);
          tick();
        end
        px(8'($urandom), 1'($urandom_range(0, 99) < rp));
      end
      finish();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
